// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: the decoded-instruction record passed from
// decode to rename/dispatch, plus the default instruction-queue depth.
package rv32i_types;

  localparam int IQ_DEPTH = 16;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_curr;
    logic [31:0] pc_next;
    logic [31:0] instr;
    logic        predict_branch;
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
  } instruction_info_reg_t;

endpackage

// File: rtl/instruction_queue.sv
// Decoupling queue between decode and rename/dispatch: circular buffer with
// wrap-bit pointers, flush for mispredict recovery, no enqueue-to-dequeue bypass.
module instruction_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       enq_valid,
  input  instruction_info_reg_t      enq_data,
  output logic                       enq_ready,
  output logic                       deq_valid,
  output instruction_info_reg_t      deq_data,
  input  logic                       deq_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  instruction_info_reg_t mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          isEmpty, isFull;
  logic          doEnq, doDeq;

  // Full/empty depend only on registered pointers, so enq_ready never sees deq_ready.
  assign isEmpty = (head_q == tail_q);
  assign isFull  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);

  assign enq_ready = !isFull;
  assign deq_valid = !isEmpty;
  assign deq_data  = mem_q[head_q[AW-1:0]];
  assign count     = tail_q - head_q;

  assign doEnq = enq_valid && !isFull && !flush;
  assign doDeq = deq_ready && !isEmpty && !flush;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (doDeq) head_d = head_q + 1'b1;
      if (doEnq) tail_d = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (doEnq) mem_q[tail_q[AW-1:0]] <= enq_data;
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue with a scoreboard of expected entries.
module tb_instruction_queue;
  import rv32i_types::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  logic                  enq_valid;
  instruction_info_reg_t enq_data;
  logic                  enq_ready;
  logic                  deq_valid;
  instruction_info_reg_t deq_data;
  logic                  deq_ready;
  logic [4:0]            count;

  int total = 0;
  int bad = 0;
  instruction_info_reg_t sb[$];
  int tailCnt = 0;
  logic [31:0] nextPc = 32'h1000;

  instruction_queue #(.DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .deq_ready (deq_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic instruction_info_reg_t mkEntry(input logic [31:0] pc);
    instruction_info_reg_t e;
    e                = '0;
    e.valid          = 1'b1;
    e.pc_curr        = pc;
    e.pc_next        = pc + 32'd4;
    e.instr          = pc ^ 32'hA5A5_0013;
    e.predict_branch = pc[3];
    e.rd_addr        = pc[6:2];
    e.rs1_addr       = pc[11:7];
    e.rs2_addr       = ~pc[6:2];
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check against the model, then update it.
  task automatic applyStimulus(input logic enqv, input logic deqr, input logic fl);
    instruction_info_reg_t exp;
    logic canEnq;
    logic canDeq;
    @(negedge clk);
    enq_valid = enqv;
    deq_ready = deqr;
    flush     = fl;
    enq_data  = fl ? mkEntry(32'hDEAD_0000) : mkEntry(nextPc);
    #1;
    canEnq = (sb.size() < 16);
    canDeq = (sb.size() != 0);
    checkOutput("count", 128'(count), 128'(sb.size()));
    checkOutput("deq_valid", 128'(deq_valid), 128'(canDeq));
    checkOutput("enq_ready", 128'(enq_ready), 128'(canEnq));
    checkOutput("tail_ptr", 128'(dut.tail_q), 128'(tailCnt));
    if (fl) begin
      sb.delete();
      tailCnt = 0;
    end else begin
      if (deqr && canDeq) begin
        exp = sb.pop_front();
        checkOutput("deq_data", 128'(deq_data), 128'(exp));
      end
      if (enqv && canEnq) begin
        sb.push_back(enq_data);
        tailCnt = (tailCnt + 1) % 32;
        nextPc  = nextPc + 32'd4;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_data  = '0;
    #1;
    checkOutput("rst_deq_valid", 128'(deq_valid), 128'(0));
    checkOutput("rst_enq_ready", 128'(enq_ready), 128'(1));
    checkOutput("rst_count", 128'(count), 128'(0));
    checkOutput("rst_entry_valid", 128'(dut.mem_q[0].valid), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to 16, then a 17th attempt must be refused.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Dequeue 10, enqueue 10 more across the wrap, then drain in order.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b1, 1'b0);

    // Occupancy 5 with concurrent enqueue/dequeue for 8 cycles.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Full queue with both handshakes: only the dequeue happens.
    for (int i = 0; i < 11; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Drain to 7, flush with a concurrent enqueue, then confirm emptiness.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0);

    // Async reset at occupancy 9, between clock edges.
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_deq_valid", 128'(deq_valid), 128'(0));
    checkOutput("async_count", 128'(count), 128'(0));
    checkOutput("async_enq_ready", 128'(enq_ready), 128'(1));
    sb.delete();
    tailCnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // First enqueue after reset is accepted on the first edge.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
